ent_ram_arbiter: RTL

Shares one single-port entity/tile RAM between the VGA renderer's per-pixel entity lookups and the game logic's board reads and writes. Runs entirely in the `vga_clk` domain between `game_logic` and the renderer path that feeds `vga_draw`. The renderer has absolute priority. Game writes are buffered in a small FIFO and drained in free slots. Game reads are granted only once every buffered write has committed, so the game always reads its own writes.

---
 rtl/ent_ram_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ent_ram_arbiter.sv
// ent_ram_arbiter: shares one single-port entity/tile RAM between renderer
// lookups (absolute priority), a buffered game-write FIFO and game reads.
// Game reads are granted only once the write FIFO is empty (read-own-writes).
// Optional build macro ENT_ARB_STATS_EN adds a saturating stall counter port.
`timescale 1ns/1ps

module ent_ram_arbiter #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  input  logic              g_rd_req,
  input  logic [ADDR_W-1:0] g_rd_addr,
  output logic              g_rd_gnt,
  output logic [DATA_W-1:0] g_rd_data,
  output logic              g_rd_valid,
  input  logic              g_wr_valid,
  input  logic [ADDR_W-1:0] g_wr_addr,
  input  logic [DATA_W-1:0] g_wr_data,
  output logic              g_wr_ready,
  output logic              wr_empty,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ENT_ARB_STATS_EN
  output logic [15:0]       stall_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_RENDER = 2'd1,
    SLOT_DRAIN  = 2'd2,
    SLOT_GAME   = 2'd3
  } slot_t;

  wr_entry_t         fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  slot_t             slot;
  wr_entry_t         head;

  logic              nxt_mem_en;
  logic              nxt_mem_we;
  logic [ADDR_W-1:0] nxt_mem_addr;
  logic [DATA_W-1:0] nxt_mem_wdata;

  logic              tag1_r_q;
  logic              tag1_g_q;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign g_wr_ready = !fifo_full;
  assign wr_empty   = fifo_empty;
  assign push       = g_wr_valid && !fifo_full;
  assign head       = fifo_q[rd_ptr_q];

  // Fixed-priority slot decision and next RAM command
  always_comb begin
    slot          = SLOT_IDLE;
    nxt_mem_en    = 1'b0;
    nxt_mem_we    = 1'b0;
    nxt_mem_addr  = mem_addr;
    nxt_mem_wdata = mem_wdata;
    if (r_req) begin
      slot = SLOT_RENDER;
    end else if (!fifo_empty) begin
      slot = SLOT_DRAIN;
    end else if (g_rd_req) begin
      slot = SLOT_GAME;
    end
    case (slot)
      SLOT_RENDER: begin
        nxt_mem_en   = 1'b1;
        nxt_mem_addr = r_addr;
      end
      SLOT_DRAIN: begin
        nxt_mem_en    = 1'b1;
        nxt_mem_we    = 1'b1;
        nxt_mem_addr  = head.addr;
        nxt_mem_wdata = head.data;
      end
      SLOT_GAME: begin
        nxt_mem_en   = 1'b1;
        nxt_mem_addr = g_rd_addr;
      end
      default: ;
    endcase
  end

  assign pop       = (slot == SLOT_DRAIN);
  assign g_rd_gnt  = (slot == SLOT_GAME);
  assign r_data    = mem_rdata;
  assign g_rd_data = mem_rdata;

  // Write FIFO storage (flushed by pointer reset, contents need no reset)
  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{addr: g_wr_addr, data: g_wr_data};
    end
  end

  // Write FIFO pointers and occupancy
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered RAM command presented the cycle after the decision
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en    <= nxt_mem_en;
      mem_we    <= nxt_mem_we;
      mem_addr  <= nxt_mem_addr;
      mem_wdata <= nxt_mem_wdata;
    end
  end

  // Two-stage read tag pipeline steering RAM data to its requester
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      tag1_r_q   <= 1'b0;
      tag1_g_q   <= 1'b0;
      r_valid    <= 1'b0;
      g_rd_valid <= 1'b0;
    end else begin
      tag1_r_q   <= (slot == SLOT_RENDER);
      tag1_g_q   <= (slot == SLOT_GAME);
      r_valid    <= tag1_r_q;
      g_rd_valid <= tag1_g_q;
    end
  end

`ifdef ENT_ARB_STATS_EN
  logic stall;
  assign stall = (g_wr_valid && !g_wr_ready) || (g_rd_req && !g_rd_gnt);

  // Saturating count of cycles where game traffic was held off
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
